// File: rtl/keypad_input_conditioner.sv
// Synchronises and debounces the keypad, start/stop buttons and door switch for the microwave controller.
// Defining KEYPAD_REPEAT_EN adds auto-repeat of a held digit every REPEAT_CYCLES clocks.
module keypad_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [9:0] keypad_raw,
    input  logic       startn_raw,
    input  logic       stopn_raw,
    input  logic       door_raw,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       key_error,
    output logic       startn,
    output logic       stopn,
    output logic       door_closed
);
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    // Button vector order is {door, stopn, startn}; buttons idle high, door idles open.
    localparam logic [2:0] BTN_RESET = 3'b011;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, RELEASE} state_t;

    function automatic logic is_onehot(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    function automatic logic [3:0] onehot_index(input logic [9:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [9:0]    k_meta_r, k_sync_r;
    logic [2:0]    b_meta_r, b_sync_r;
    state_t        state_r, next_state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [9:0]    held_r, held_s;
    logic          emit_s, err_s, rep_fire_s;
    logic [2:0]    lvl_r, accept_s;
    logic [CW-1:0] bcnt_r [3];
    logic [3:0]    digit_r;
    logic          digit_valid_r, key_error_r, startn_r, stopn_r;

    // Two-flop synchronisers for every raw input.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            k_meta_r <= 10'd0;
            k_sync_r <= 10'd0;
            b_meta_r <= BTN_RESET;
            b_sync_r <= BTN_RESET;
        end else begin
            k_meta_r <= keypad_raw;
            k_sync_r <= k_meta_r;
            b_meta_r <= {door_raw, stopn_raw, startn_raw};
            b_sync_r <= b_meta_r;
        end
    end

    // Keypad FSM next-state and strobe decode.
    always_comb begin
        next_state_s = state_r;
        cnt_s        = cnt_r;
        held_s       = held_r;
        emit_s       = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (k_sync_r != 10'd0) begin
                    held_s       = k_sync_r;
                    cnt_s        = '0;
                    next_state_s = DEBOUNCE;
                end else begin
                    cnt_s = '0;
                end
            end
            DEBOUNCE: begin
                if (k_sync_r != held_r) begin
                    next_state_s = IDLE;
                end else if (cnt_r == DEB_LAST) begin
                    cnt_s = '0;
                    if (is_onehot(held_r)) begin
                        emit_s       = 1'b1;
                        next_state_s = EMIT;
                    end else begin
                        err_s        = 1'b1;
                        next_state_s = RELEASE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            EMIT: begin
                cnt_s        = '0;
                next_state_s = RELEASE;
            end
            RELEASE: begin
                if (k_sync_r != 10'd0) begin
                    cnt_s = '0;
                end else if (cnt_r == DEB_LAST) begin
                    cnt_s        = '0;
                    next_state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                cnt_s        = '0;
                next_state_s = IDLE;
            end
        endcase
    end

`ifdef KEYPAD_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
    logic [CW-1:0] rep_cnt_r, rep_cnt_s;

    // Repeat counter runs only while the accepted key stays exactly as pressed.
    always_comb begin
        rep_cnt_s  = '0;
        rep_fire_s = 1'b0;
        if (state_r == RELEASE && k_sync_r == held_r) begin
            if (rep_cnt_r == REP_LAST) begin
                rep_fire_s = 1'b1;
            end else begin
                rep_cnt_s = rep_cnt_r + CNT_ONE;
            end
        end else begin
            rep_cnt_s = '0;
        end
    end

    // Repeat counter register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rep_cnt_r <= '0;
        end else begin
            rep_cnt_r <= rep_cnt_s;
        end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    // Keypad FSM state and registered digit outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            held_r        <= 10'd0;
            digit_r       <= 4'd0;
            digit_valid_r <= 1'b0;
            key_error_r   <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            cnt_r         <= cnt_s;
            held_r        <= held_s;
            digit_valid_r <= emit_s | rep_fire_s;
            key_error_r   <= err_s;
            if (emit_s) begin
                digit_r <= onehot_index(held_r);
            end else begin
                digit_r <= digit_r;
            end
        end
    end

    // A new level is accepted on the last of DEBOUNCE_CYCLES differing samples.
    always_comb begin
        accept_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            accept_s[i] = (b_sync_r[i] != lvl_r[i]) && (bcnt_r[i] == DEB_LAST);
        end
    end

    // Button/door debounce counters, accepted levels and falling-edge pulses.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lvl_r    <= BTN_RESET;
            startn_r <= 1'b1;
            stopn_r  <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                bcnt_r[i] <= '0;
            end
        end else begin
            startn_r <= ~(accept_s[0] & lvl_r[0]);
            stopn_r  <= ~(accept_s[1] & lvl_r[1]);
            for (int i = 0; i < 3; i++) begin
                if (b_sync_r[i] == lvl_r[i]) begin
                    bcnt_r[i] <= '0;
                end else if (accept_s[i]) begin
                    bcnt_r[i] <= '0;
                    lvl_r[i]  <= b_sync_r[i];
                end else begin
                    bcnt_r[i] <= bcnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    assign digit       = digit_r;
    assign digit_valid = digit_valid_r;
    assign key_error   = key_error_r;
    assign startn      = startn_r;
    assign stopn       = stopn_r;
    assign door_closed = lvl_r[2];
endmodule

// File: tb/tb_keypad_input_conditioner.sv
// Scoreboard bench for keypad_input_conditioner: stimulus queues expected strobes with their cycle, a monitor pops them.
module tb_keypad_input_conditioner;
    localparam int REP = 64;
    localparam int K_DIGIT = 0, K_ERR = 1, K_START = 2, K_STOP = 3;

    logic       clock = 1'b0;
    logic       resetn;
    logic [9:0] keypad_raw;
    logic       startn_raw, stopn_raw, door_raw;
    logic [3:0] digit;
    logic       digit_valid, key_error, startn, stopn, door_closed;

    typedef struct {
        int         kind;
        logic [3:0] val;
        int         cyc;
    } evt_t;

    evt_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    keypad_input_conditioner dut (
        .clock(clock), .resetn(resetn), .keypad_raw(keypad_raw),
        .startn_raw(startn_raw), .stopn_raw(stopn_raw), .door_raw(door_raw),
        .digit(digit), .digit_valid(digit_valid), .key_error(key_error),
        .startn(startn), .stopn(stopn), .door_closed(door_closed)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_DIGIT: return "digit_valid";
            K_ERR:   return "key_error";
            K_START: return "startn";
            default: return "stopn";
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_evt(input int kind, input logic [3:0] val, input int at);
        evt_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_evt(input int kind, input logic [3:0] val);
        evt_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected %s: got val=%0d at cycle %0d, expected no event", kname(kind), val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
                errors++;
                $display("FAIL event %s: got val=%0d cycle=%0d, expected %s val=%0d cycle=%0d",
                         kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    // Monitor: every strobe the DUT presents is matched against the scoreboard.
    always @(negedge clock) begin
        if (resetn === 1'b1) begin
            if (digit_valid) check_evt(K_DIGIT, digit);
            if (key_error)   check_evt(K_ERR, 4'd0);
            if (!startn)     check_evt(K_START, 4'd0);
            if (!stopn)      check_evt(K_STOP, 4'd0);
        end
    end

    task automatic press(input logic [9:0] keys, input int hold, input int idle);
        keypad_raw = keys;
        tick(hold);
        keypad_raw = 10'd0;
        tick(idle);
    endtask

    initial begin
        int c;
        int r;
        logic [3:0] seq [3];
        seq[0] = 4'd1; seq[1] = 4'd4; seq[2] = 4'd0;

        resetn = 1'b0; keypad_raw = 10'd0;
        startn_raw = 1'b1; stopn_raw = 1'b1; door_raw = 1'b0;
        tick(3);
        check_eq("reset digit", 32'(digit), 32'd0);
        check_eq("reset digit_valid", 32'(digit_valid), 32'd0);
        check_eq("reset key_error", 32'(key_error), 32'd0);
        check_eq("reset startn", 32'(startn), 32'd1);
        check_eq("reset stopn", 32'(stopn), 32'd1);
        check_eq("reset door_closed", 32'(door_closed), 32'd0);
        resetn = 1'b1;
        tick(5);

        // single key 1, strobe at edge 7 after the raw change
        push_evt(K_DIGIT, 4'd1, cyc + 7);
        press(10'b0000000010, 10, 10);
        check_eq("digit holds", 32'(digit), 32'd1);

        // sequence 1,4,0
        for (int i = 0; i < 3; i++) begin
            push_evt(K_DIGIT, seq[i], cyc + 7);
            press(10'd1 << seq[i], 10, 10);
        end

        // 2-clock glitch and 3-clock short press produce nothing; next press has normal latency
        press(10'b0000000001, 2, 10);
        press(10'b0010000000, 3, 10);
        push_evt(K_DIGIT, 4'd3, cyc + 7);
        press(10'b0000001000, 10, 10);

        // multi-key 4+9 rejected, then clean 9
        push_evt(K_ERR, 4'd0, cyc + 7);
        press(10'b1000010000, 10, 10);
        push_evt(K_DIGIT, 4'd9, cyc + 7);
        press(10'b1000000000, 10, 10);

        // second key added while first still held: one strobe only
        push_evt(K_DIGIT, 4'd2, cyc + 7);
        keypad_raw = 10'b0000000100;
        tick(9);
        keypad_raw = 10'b0000010100;
        tick(10);
        keypad_raw = 10'd0;
        tick(10);

        // start and stop together: coincident single pulses, nothing on release
        push_evt(K_START, 4'd0, cyc + 6);
        push_evt(K_STOP, 4'd0, cyc + 6);
        startn_raw = 1'b0; stopn_raw = 1'b0;
        tick(20);
        startn_raw = 1'b1; stopn_raw = 1'b1;
        tick(12);
        startn_raw = 1'b0;
        tick(2);
        startn_raw = 1'b1;
        tick(10);

        // door close/open debounce
        door_raw = 1'b1;
        tick(5);
        check_eq("door before accept", 32'(door_closed), 32'd0);
        tick(1);
        check_eq("door closed accept", 32'(door_closed), 32'd1);
        door_raw = 1'b0;
        tick(2);
        door_raw = 1'b1;
        tick(8);
        check_eq("door open glitch", 32'(door_closed), 32'd1);
        door_raw = 1'b0;
        tick(5);
        check_eq("door before open", 32'(door_closed), 32'd1);
        tick(1);
        check_eq("door open accept", 32'(door_closed), 32'd0);
        door_raw = 1'b1;
        tick(10);
        check_eq("door closed again", 32'(door_closed), 32'd1);

        // key 5 held 300 clocks with reset pulse at clock 5
        c = cyc;
        keypad_raw = 10'b0000100000;
        tick(5);
        resetn = 1'b0;
        #1;
        check_eq("midreset digit", 32'(digit), 32'd0);
        check_eq("midreset digit_valid", 32'(digit_valid), 32'd0);
        check_eq("midreset door_closed", 32'(door_closed), 32'd0);
        check_eq("midreset startn", 32'(startn), 32'd1);
        tick(1);
        resetn = 1'b1;
        r = cyc;
        push_evt(K_DIGIT, 4'd5, r + 7);
`ifdef KEYPAD_REPEAT_EN
        for (int t = r + 8 + REP; t <= c + 300; t += REP) begin
            push_evt(K_DIGIT, 4'd5, t);
        end
`endif
        tick(c + 300 - cyc);
        keypad_raw = 10'd0;
        tick(20);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing events: got %0d still pending, expected 0 (next %s at cycle %0d)",
                     exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
